regfile_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage integer register file.
- Adds configurable read-port and write-port counts, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- Decode reads operands and hazard status from it; issue marks destinations pending; one or more writeback paths (ALU, load) retire results.
- Sits between the decode, issue and writeback stages of the pipeline core.

---
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the pipeline stages and the register file / busy scoreboard.
// The master side is the pipeline (decode, issue, writeback); the slave side is the register file.
interface regfile_scoreboard_if #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]   rs_addr;
   logic [NUM_RD*XLEN-1:0] rs_data;
   logic [NUM_RD-1:0]      rs_busy;
   logic [NUM_WR-1:0]      wr_en;
   logic [NUM_WR*AW-1:0]   wr_addr;
   logic [NUM_WR*XLEN-1:0] wr_data;
   logic                   issue_en;
   logic [AW-1:0]          issue_rd;
   logic                   flush;
   logic                   stall;
   logic [AW:0]            busy_count;

   modport master (
      output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush,
      input  rs_data, rs_busy, stall, busy_count
   );

   modport slave (
      input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush,
      output rs_data, rs_busy, stall, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard. Register 0 is hardwired to zero and never busy.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0]        regs_r [NUM_REGS];
   logic [NUM_REGS-1:0]    busy_r;
   logic [AW:0]            busy_count_r;
   logic [NUM_REGS-1:0]    busy_next_s;
   logic [NUM_RD*XLEN-1:0] rd_data_s;
   logic [NUM_RD-1:0]      rd_busy_s;
   logic                   stall_s;
   logic                   issue_ok_s;

   // Population count of a busy vector; fits in AW+1 bits.
   function automatic logic [AW:0] count_ones(input logic [NUM_REGS-1:0] v);
      logic [AW:0] c;
      c = {(AW+1){1'b0}};
      for (int k = 0; k < NUM_REGS; k++) begin
         c = c + {{AW{1'b0}}, v[k]};
      end
      return c;
   endfunction

   // WAW hazard detection and the qualified issue that may set a busy bit.
   always_comb begin
      stall_s    = bus.issue_en && (bus.issue_rd != {AW{1'b0}}) && busy_r[bus.issue_rd];
      issue_ok_s = bus.issue_en && (bus.issue_rd != {AW{1'b0}}) && !busy_r[bus.issue_rd];
   end

   // Next busy vector: write clears, then a new producer sets, then flush clears all.
   always_comb begin
      busy_next_s = busy_r;
      for (int p = 0; p < NUM_WR; p++) begin
         busy_next_s[bus.wr_addr[p*AW +: AW]] = bus.wr_en[p] ? 1'b0
                                                : busy_next_s[bus.wr_addr[p*AW +: AW]];
      end
      busy_next_s[bus.issue_rd] = issue_ok_s ? 1'b1 : busy_next_s[bus.issue_rd];
      busy_next_s    = bus.flush ? {NUM_REGS{1'b0}} : busy_next_s;
      busy_next_s[0] = 1'b0;
   end

   // Read ports: stored value, optionally overridden by a same-cycle write (highest port wins).
   always_comb begin
      rd_data_s = {(NUM_RD*XLEN){1'b0}};
      rd_busy_s = {NUM_RD{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data_s[i*XLEN +: XLEN] = regs_r[bus.rs_addr[i*AW +: AW]];
         rd_busy_s[i]              = busy_r[bus.rs_addr[i*AW +: AW]];
         for (int p = 0; p < NUM_WR; p++) begin
            rd_data_s[i*XLEN +: XLEN] =
               ((BYPASS != 0) && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == bus.rs_addr[i*AW +: AW]))
               ? bus.wr_data[p*XLEN +: XLEN] : rd_data_s[i*XLEN +: XLEN];
            rd_busy_s[i] =
               ((BYPASS != 0) && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == bus.rs_addr[i*AW +: AW]))
               ? 1'b0 : rd_busy_s[i];
         end
         rd_data_s[i*XLEN +: XLEN] = (bus.rs_addr[i*AW +: AW] == {AW{1'b0}})
                                     ? {XLEN{1'b0}} : rd_data_s[i*XLEN +: XLEN];
         rd_busy_s[i] = (bus.rs_addr[i*AW +: AW] == {AW{1'b0}}) ? 1'b0 : rd_busy_s[i];
      end
   end

   // Register storage: ascending port order so the highest-index write to an address lands last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_r[r] <= {XLEN{1'b0}};
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != {AW{1'b0}})) begin
               regs_r[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   // Scoreboard state and its registered population count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r       <= {NUM_REGS{1'b0}};
         busy_count_r <= {(AW+1){1'b0}};
      end else begin
         busy_r       <= busy_next_s;
         busy_count_r <= count_ones(busy_next_s);
      end
   end

   assign bus.rs_data    = rd_data_s;
   assign bus.rs_busy    = rd_busy_s;
   assign bus.stall      = stall_s;
   assign bus.busy_count = busy_count_r;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, all compared against a behavioural register/scoreboard model.
module tb_regfile_scoreboard;
   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 2;
   localparam int NUM_WR   = 2;
   localparam int BYPASS   = 1;
   localparam int AW       = $clog2(NUM_REGS);

   logic clk = 1'b0;
   logic rst;

   int vectors     = 0;
   int miscompares = 0;

   logic [XLEN-1:0] m_reg  [NUM_REGS];
   bit              m_busy [NUM_REGS];

   regfile_scoreboard_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

   regfile_scoreboard #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_clear();
      for (int r = 0; r < NUM_REGS; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   task automatic idle();
      bus.rs_addr  = '0;
      bus.wr_en    = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.issue_en = 1'b0;
      bus.issue_rd = '0;
      bus.flush    = 1'b0;
   endtask

   task automatic set_rd(input int i, input int a);
      bus.rs_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
      bus.wr_en[p]                = 1'b1;
      bus.wr_addr[p*AW +: AW]     = AW'(a);
      bus.wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic set_issue(input int a);
      bus.issue_en = 1'b1;
      bus.issue_rd = AW'(a);
   endtask

   function automatic int model_count();
      int n = 0;
      for (int r = 0; r < NUM_REGS; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   function automatic bit model_stall();
      int ir = int'(bus.issue_rd);
      return bus.issue_en && ir != 0 && m_busy[ir];
   endfunction

   // Compare every output against what the model says for the current inputs.
   task automatic settle_check();
      #1;
      for (int i = 0; i < NUM_RD; i++) begin
         int a;
         logic [XLEN-1:0] ed;
         bit eb;
         a  = int'(bus.rs_addr[i*AW +: AW]);
         ed = m_reg[a];
         eb = m_busy[a];
         if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (bus.wr_en[p] && int'(bus.wr_addr[p*AW +: AW]) == a) begin
                  ed = bus.wr_data[p*XLEN +: XLEN];
                  eb = 1'b0;
               end
            end
         end
         if (a == 0) begin
            ed = '0;
            eb = 1'b0;
         end
         chk($sformatf("rs_data%0d", i), 64'(bus.rs_data[i*XLEN +: XLEN]), 64'(ed));
         chk($sformatf("rs_busy%0d", i), 64'(bus.rs_busy[i]), 64'(eb));
      end
      chk("stall", 64'(bus.stall), 64'(model_stall()));
      chk("busy_count", 64'(bus.busy_count), 64'(model_count()));
   endtask

   // Advance one clock and apply the architectural update rules to the model.
   task automatic tick();
      bit st;
      st = model_stall();
      @(posedge clk);
      if (rst) begin
         m_clear();
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            int a = int'(bus.wr_addr[p*AW +: AW]);
            if (bus.wr_en[p] && a != 0) begin
               m_reg[a]  = bus.wr_data[p*XLEN +: XLEN];
               m_busy[a] = 1'b0;
            end
         end
         if (bus.issue_en && bus.issue_rd != 0 && !st) m_busy[int'(bus.issue_rd)] = 1'b1;
         if (bus.flush) for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      m_clear();
      @(negedge clk);
      set_rd(0, 5); set_rd(1, 31);
      settle_check();
      tick();
      rst = 1'b0;

      // Reset state
      idle(); set_rd(0, 5); set_rd(1, 31);
      settle_check();
      chk("reset_x5", 64'(bus.rs_data[0 +: XLEN]), 64'h0);
      chk("reset_cnt", 64'(bus.busy_count), 64'h0);
      tick();

      // Basic write, then x0 write ignored
      idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 1); set_rd(1, 2);
      settle_check(); tick();
      idle(); set_rd(0, 5); set_wr(1, 0, 32'h00001234);
      settle_check();
      chk("x5_stored", 64'(bus.rs_data[0 +: XLEN]), 64'hDEADBEEF);
      tick();
      idle(); set_rd(1, 0);
      settle_check();
      chk("x0_zero", 64'(bus.rs_data[XLEN +: XLEN]), 64'h0);
      tick();

      // Same-cycle bypass
      idle(); set_wr(1, 7, 32'hA5A5A5A5); set_rd(0, 7);
      settle_check();
      chk("bypass_x7", 64'(bus.rs_data[0 +: XLEN]), (BYPASS != 0) ? 64'hA5A5A5A5 : 64'h0);
      tick();

      // Write collision: highest port wins
      idle(); set_wr(0, 9, 32'h11); set_wr(1, 9, 32'h22);
      settle_check(); tick();
      idle(); set_rd(0, 9);
      settle_check();
      chk("collide_x9", 64'(bus.rs_data[0 +: XLEN]), 64'h22);
      tick();

      // Scoreboard: issue, stall, clear, set-beats-clear
      idle(); set_issue(3); settle_check(); tick();
      idle(); set_rd(0, 3); set_issue(3);
      settle_check();
      chk("x3_busy", 64'(bus.rs_busy[0]), 64'h1);
      chk("cnt_one", 64'(bus.busy_count), 64'h1);
      chk("waw_stall", 64'(bus.stall), 64'h1);
      tick();
      idle(); set_wr(0, 3, 32'h33); settle_check(); tick();
      idle(); set_rd(0, 3);
      settle_check();
      chk("x3_clear", 64'(bus.busy_count), 64'h0);
      tick();
      idle(); set_issue(4); set_wr(1, 4, 32'h44); settle_check(); tick();
      idle(); set_rd(1, 4);
      settle_check();
      chk("x4_set_wins", 64'(bus.rs_busy[1]), 64'h1);
      tick();

      // Flush beats a simultaneous issue
      idle(); set_issue(3); settle_check(); tick();
      idle(); set_issue(8); settle_check(); tick();
      idle(); bus.flush = 1'b1; set_issue(10); settle_check(); tick();
      idle(); set_rd(0, 10); set_rd(1, 8);
      settle_check();
      chk("flush_cnt", 64'(bus.busy_count), 64'h0);
      tick();

      // Reset asserted during a write wipes state immediately
      idle(); set_wr(0, 6, 32'h66); settle_check(); tick();
      idle(); set_wr(0, 6, 32'h77); set_rd(0, 6);
      #2 rst = 1'b1;
      m_clear();
      bus.wr_en = '0;
      settle_check();
      chk("rst_x6", 64'(bus.rs_data[0 +: XLEN]), 64'h0);
      tick();
      rst = 1'b0;
      idle(); set_rd(0, 6); settle_check(); tick();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         idle();
         for (int i = 0; i < NUM_RD; i++) set_rd(i, $urandom_range(0, (n % 2) ? 7 : NUM_REGS - 1));
         for (int p = 0; p < NUM_WR; p++) begin
            if ($urandom_range(0, 2) == 0) set_wr(p, $urandom_range(0, 7), $urandom);
         end
         if ($urandom_range(0, 1) == 0) set_issue($urandom_range(0, 7));
         bus.flush = ($urandom_range(0, 15) == 0);
         settle_check();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
